uart_receiver_fsm: RTL and testbench

UART_RECEIVER_FSM -- requirements
Module: uart_receiver_fsm

---
 rtl/uart_receiver_fsm.sv | 131 +++++++++++++
 tb/tb_uart_receiver_fsm.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_receiver_fsm.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, registered
// valid / frame_err pulses and a held output byte.
module uart_receiver_fsm #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    dout_q, dout_d;
   logic          valid_q, valid_d;
   logic          frame_err_q, frame_err_d;
   logic          rx_meta_q, rx_meta_d;
   logic          rx_s_q, rx_s_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         dout_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         rx_meta_q   <= 1'b1;
         rx_s_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         dout_q      <= dout_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         rx_meta_q   <= rx_meta_d;
         rx_s_q      <= rx_s_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      dout_d      = dout_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      rx_meta_d   = rx;
      rx_s_d      = rx_meta_q;

      unique case (state_q)
         IDLE: begin
            if (!rx_s_q) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            // Half a bit in: a high line here means the falling edge was noise.
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               idx_d = '0;
               state_d = rx_s_q ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s_q, shift_q[7:1]};
               if (idx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  dout_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_IDLE: begin
            if (rx_s_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign dout      = dout_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver_fsm.sv
// Bench for uart_receiver_fsm: directed frames plus random byte stream
// checked against a queue of transmitted bytes.
module tb_uart_receiver_fsm;

   localparam int unsigned CPB = 4;

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] dout;
   logic       valid;
   logic       frame_err;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;
   int valid_cnt = 0;
   int ferr_cnt = 0;
   logic [7:0] exp_q[$];

   uart_receiver_fsm #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .dout      (dout),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Pulse monitor: every valid must match the oldest transmitted good byte.
   always @(posedge clk) begin
      #1;
      if (valid || frame_err) begin
         check_eq("pulse_exclusive", {31'd0, valid & frame_err}, 32'd0);
      end
      if (valid) begin
         valid_cnt++;
         check_eq("valid_expected", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            check_eq("dout", {24'd0, dout}, {24'd0, exp_q.pop_front()});
         end
      end
      if (frame_err) begin
         ferr_cnt++;
      end
   end

   task automatic drive_bit(input logic v);
      rx = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_v);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         drive_bit(b[i]);
      end
      drive_bit(stop_v);
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * CPB) @(negedge clk);
   endtask

   initial begin
      int v0;
      int f0;
      int busy_cycles;
      logic [7:0] b;

      rx  = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_dout", {24'd0, dout}, 32'd0);
      check_eq("rst_valid", {31'd0, valid}, 32'd0);
      check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      idle_bits(2);

      // Single good frame
      v0 = valid_cnt; f0 = ferr_cnt;
      exp_q.push_back(8'hA5);
      send_byte(8'hA5, 1'b1);
      idle_bits(3);
      check_eq("a5_valid_count", valid_cnt - v0, 1);
      check_eq("a5_ferr_count", ferr_cnt - f0, 0);
      check_eq("a5_dout", {24'd0, dout}, 32'hA5);
      check_eq("a5_busy_idle", {31'd0, busy}, 32'd0);

      // Back-to-back frames
      v0 = valid_cnt;
      exp_q.push_back(8'h55);
      exp_q.push_back(8'h0F);
      send_byte(8'h55, 1'b1);
      send_byte(8'h0F, 1'b1);
      idle_bits(3);
      check_eq("b2b_valid_count", valid_cnt - v0, 2);
      check_eq("b2b_dout", {24'd0, dout}, 32'h0F);

      // Bad stop bit followed by a held-low break
      v0 = valid_cnt; f0 = ferr_cnt;
      send_byte(8'h3C, 1'b0);
      rx = 1'b0;
      repeat (20 * CPB) @(negedge clk);
      check_eq("break_ferr_count", ferr_cnt - f0, 1);
      check_eq("break_valid_count", valid_cnt - v0, 0);
      check_eq("break_dout_held", {24'd0, dout}, 32'h0F);
      check_eq("break_busy", {31'd0, busy}, 32'd1);
      idle_bits(3);
      check_eq("break_busy_released", {31'd0, busy}, 32'd0);
      check_eq("break_ferr_total", ferr_cnt - f0, 1);

      // One-clock glitch on an idle line
      v0 = valid_cnt; f0 = ferr_cnt;
      busy_cycles = 0;
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (busy) busy_cycles++;
         @(negedge clk);
      end
      check_eq("glitch_busy_seen", {31'd0, busy_cycles > 0}, 32'd1);
      check_eq("glitch_busy_max", {31'd0, busy_cycles <= int'(CPB / 2 + 1)}, 32'd1);
      check_eq("glitch_pulses", (valid_cnt - v0) + (ferr_cnt - f0), 0);
      check_eq("glitch_busy_end", {31'd0, busy}, 32'd0);

      // Reset two clocks into data bit 4 of 8'hFF, then a clean frame
      v0 = valid_cnt; f0 = ferr_cnt;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("abort_busy", {31'd0, busy}, 32'd0);
      check_eq("abort_dout_cleared", {24'd0, dout}, 32'd0);
      repeat (CPB - 3) @(negedge clk);
      idle_bits(4);
      check_eq("abort_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 0);
      exp_q.push_back(8'h81);
      send_byte(8'h81, 1'b1);
      idle_bits(3);
      check_eq("resume_valid_count", valid_cnt - v0, 1);
      check_eq("resume_dout", {24'd0, dout}, 32'h81);

      // Random stream with 0-3 bit-period idle gaps
      v0 = valid_cnt; f0 = ferr_cnt;
      for (int n = 0; n < 200; n++) begin
         b = 8'($urandom_range(0, 255));
         exp_q.push_back(b);
         send_byte(b, 1'b1);
         idle_bits(int'($urandom_range(0, 3)));
      end
      idle_bits(3);
      check_eq("rand_valid_count", valid_cnt - v0, 200);
      check_eq("rand_ferr_count", ferr_cnt - f0, 0);
      check_eq("rand_queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
